// File: rtl/xeng_corr_apply.sv
// Subtracts per-baseline DC/offset corrections (buffered in an order-aligned FIFO) from X-engine correlations.
// Define XENG_CORR_APPLY_SAT_EN to clamp per-lane results; otherwise results wrap to DATA_WIDTH bits.
module xeng_corr_apply #(
  parameter int CORR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 24,
  parameter int FIFO_DEPTH_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync,
  input  logic                    corr_vld,
  input  logic [8*CORR_WIDTH-1:0] corr_in,
  input  logic                    din_vld,
  input  logic [8*DATA_WIDTH-1:0] din,
  output logic                    dout_vld,
  output logic [8*DATA_WIDTH-1:0] dout,
  output logic                    sync_out,
  output logic                    fifo_ovf,
  output logic                    fifo_unf
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CNTW  = FIFO_DEPTH_BITS + 1;

  logic [8*CORR_WIDTH-1:0]    mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr, wr_ptr, rd_eff, wr_eff;
  logic [CNTW-1:0]            count, count_eff, count_nxt;
  logic                       empty, full, pop_mem, bypass, push, drop, underflow;
  logic [8*CORR_WIDTH-1:0]    corr_sel;

  // A sync flushes first; same-cycle push/pop then act on the flushed (empty) view.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_eff    = sync ? '0 : rd_ptr;
    wr_eff    = sync ? '0 : wr_ptr;
    count_eff = sync ? '0 : count;
    empty     = (count_eff == '0);
    full      = (count_eff == CNTW'(DEPTH));
    pop_mem   = din_vld && !empty;
    bypass    = din_vld && empty && corr_vld;
    underflow = din_vld && empty && !corr_vld;
    push      = corr_vld && !bypass && (!full || din_vld);
    drop      = corr_vld && full && !din_vld;
    count_nxt = count_eff;
    if (push && !pop_mem)      count_nxt = count_eff + CNTW'(1);
    else if (pop_mem && !push) count_nxt = count_eff - CNTW'(1);
    corr_sel = '0;
    if (pop_mem)     corr_sel = mem[rd_eff];
    else if (bypass) corr_sel = corr_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fifo_ovf <= 1'b0;
      fifo_unf <= 1'b0;
    end else begin
      rd_ptr   <= rd_eff + FIFO_DEPTH_BITS'(pop_mem);
      wr_ptr   <= wr_eff + FIFO_DEPTH_BITS'(push);
      count    <= count_nxt;
      fifo_ovf <= (fifo_ovf && !sync) || drop;
      fifo_unf <= (fifo_unf && !sync) || underflow;
    end
  end

  // NOTE: the storage array is deliberately not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_eff] <= corr_in;
  end

  // Stage 1: register data lanes and the sign-extended correction.
  logic                         vld1, sync1;
  logic signed [DATA_WIDTH-1:0] din1  [8];
  logic signed [DATA_WIDTH:0]   corr1 [8];

  always_ff @(posedge clk) begin
    if (din_vld) begin
      for (int i = 0; i < 8; i++) begin
        din1[i]  <= din[i*DATA_WIDTH +: DATA_WIDTH];
        corr1[i] <= (DATA_WIDTH+1)'(signed'(corr_sel[i*CORR_WIDTH +: CORR_WIDTH]));
      end
    end
  end

  // Stage 2: subtract in DATA_WIDTH+1 bits, then narrow per lane.
  logic [8*DATA_WIDTH-1:0] dout_nxt;

`ifdef XENG_CORR_APPLY_SAT_EN
  logic signed [DATA_WIDTH:0] diff [8];

  always_comb begin
    dout_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      diff[i] = (DATA_WIDTH+1)'(din1[i]) - corr1[i];
      if (diff[i][DATA_WIDTH] != diff[i][DATA_WIDTH-1])
        dout_nxt[i*DATA_WIDTH +: DATA_WIDTH] = diff[i][DATA_WIDTH] ?
          {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
        dout_nxt[i*DATA_WIDTH +: DATA_WIDTH] = diff[i][DATA_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    dout_nxt = '0;
    for (int i = 0; i < 8; i++)
      dout_nxt[i*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'((DATA_WIDTH+1)'(din1[i]) - corr1[i]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld1     <= 1'b0;
      sync1    <= 1'b0;
      dout_vld <= 1'b0;
      sync_out <= 1'b0;
      dout     <= '0;
    end else begin
      vld1     <= din_vld;
      sync1    <= sync;
      dout_vld <= vld1;
      sync_out <= sync1;
      if (vld1) dout <= dout_nxt;
    end
  end

endmodule

// File: tb/tb_xeng_corr_apply.sv
// Self-checking bench for xeng_corr_apply: directed scenarios plus randomized traffic against a queue model.
module tb_xeng_corr_apply;

  localparam int CW    = 16;
  localparam int DW    = 24;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst, sync, corr_vld, din_vld;
  logic [8*CW-1:0] corr_in;
  logic [8*DW-1:0] din;
  logic            dout_vld, sync_out, fifo_ovf, fifo_unf;
  logic [8*DW-1:0] dout;

  xeng_corr_apply #(.CORR_WIDTH(CW), .DATA_WIDTH(DW), .FIFO_DEPTH_BITS(5)) dut (
    .clk(clk), .rst(rst), .sync(sync), .corr_vld(corr_vld), .corr_in(corr_in),
    .din_vld(din_vld), .din(din), .dout_vld(dout_vld), .dout(dout),
    .sync_out(sync_out), .fifo_ovf(fifo_ovf), .fifo_unf(fifo_unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [8*DW-1:0] act, input logic [8*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: correction queue, sticky flags, and a two-deep output delay line.
  logic [8*CW-1:0] q[$];
  logic            m_ovf, m_unf;
  logic            m_p1_vld, m_p1_sync, m_vld, m_sync;
  logic [8*DW-1:0] m_p1_dout, m_dout;

  function automatic logic [8*DW-1:0] apply_corr(input logic [8*DW-1:0] d, input logic [8*CW-1:0] c);
    logic [8*DW-1:0]      r;
    logic signed [DW-1:0] a;
    logic signed [CW-1:0] b;
    longint               diff;
    longint               lo, hi;
    lo = -(longint'(1) <<< (DW-1));
    hi = (longint'(1) <<< (DW-1)) - 1;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      a    = d[i*DW +: DW];
      b    = c[i*CW +: CW];
      diff = longint'(a) - longint'(b);
`ifdef XENG_CORR_APPLY_SAT_EN
      if (diff < lo) diff = lo;
      if (diff > hi) diff = hi;
`endif
      r[i*DW +: DW] = diff[DW-1:0];
    end
    return r;
  endfunction

  task automatic model_step();
    logic [8*CW-1:0] c;
    if (rst) begin
      q.delete();
      {m_ovf, m_unf, m_p1_vld, m_p1_sync, m_vld, m_sync} = '0;
      m_p1_dout = '0;
      m_dout    = '0;
    end else begin
      m_vld  = m_p1_vld;
      m_sync = m_p1_sync;
      if (m_p1_vld) m_dout = m_p1_dout;
      if (sync) begin
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      c = '0;
      if (din_vld) begin
        if (q.size() > 0) begin
          c = q.pop_front();
          if (corr_vld) q.push_back(corr_in);
        end else if (corr_vld) c = corr_in;
        else m_unf = 1'b1;
      end else if (corr_vld) begin
        if (q.size() < DEPTH) q.push_back(corr_in);
        else m_ovf = 1'b1;
      end
      m_p1_vld  = din_vld;
      m_p1_sync = sync;
      m_p1_dout = apply_corr(din, c);
    end
  endtask

  task automatic compare();
    check("dout_vld", dout_vld, m_vld);
    check("sync_out", sync_out, m_sync);
    check("fifo_ovf", fifo_ovf, m_ovf);
    check("fifo_unf", fifo_unf, m_unf);
    check("dout", dout, m_dout);
    check("count", dut.count, q.size());
  endtask

  task automatic cycle(input logic r, input logic s, input logic cv, input logic [8*CW-1:0] ci,
                       input logic dv, input logic [8*DW-1:0] di);
    @(negedge clk);
    rst = r; sync = s; corr_vld = cv; corr_in = ci; din_vld = dv; din = di;
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  function automatic logic [8*CW-1:0] cl(input int v);
    logic [8*CW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*CW +: CW] = CW'(v);
    return r;
  endfunction

  function automatic logic [8*DW-1:0] dl(input int v);
    logic [8*DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, 0, '0);
  endtask

  task automatic do_sync();
    cycle(0, 1, 0, '0, 0, '0);
  endtask

  initial begin
    {rst, sync, corr_vld, din_vld} = '0;
    corr_in = '0;
    din     = '0;
    cycle(1, 0, 0, '0, 0, '0);
    cycle(1, 0, 0, '0, 0, '0);
    check("reset_dout", dout, '0);

    // Three corrections of 5, then three words of 100 -> 95.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, cl(5), 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, dl(100));
    idle(1);
    check("t1_dout95", dout, dl(95));
    check("t1_unf", fifo_unf, 1'b0);
    idle(1);

    // Pop with empty FIFO and no push.
    cycle(0, 0, 0, '0, 1, dl(7));
    idle(2);
    check("t2_dout7", dout, dl(7));
    check("t2_unf", fifo_unf, 1'b1);
    do_sync();
    check("t2_unf_clr", fifo_unf, 1'b0);

    // Fill, overflow, then push+pop while full.
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, cl(i), 0, '0);
    check("t3_full_ovf", fifo_ovf, 1'b0);
    cycle(0, 0, 1, cl(99), 0, '0);
    check("t3_ovf", fifo_ovf, 1'b1);
    check("t3_count", dut.count, 32);
    cycle(0, 0, 1, cl(77), 1, dl(1000));
    check("t3_count_pp", dut.count, 32);
    idle(2);
    check("t3_head", dout, dl(1000));
    do_sync();

    // Bypass: corr 3 and din 10 together on an empty FIFO.
    idle(1);
    cycle(0, 0, 1, cl(3), 1, dl(10));
    check("t4_count", dut.count, 0);
    idle(2);
    check("t4_dout7", dout, dl(7));
    check("t4_unf", fifo_unf, 1'b0);

    // Most-negative input minus one.
    cycle(0, 0, 1, cl(1), 1, dl(32'h0080_0000));
    idle(2);
`ifdef XENG_CORR_APPLY_SAT_EN
    check("t5_sat", dout, dl(32'h0080_0000));
`else
    check("t5_wrap", dout, dl(32'h007F_FFFF));
`endif

    // Sync flush after pushes, then pop, then reset mid-burst.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, cl(i + 1), 0, '0);
    do_sync();
    idle(1);
    check("t6_sync_out", sync_out, 1'b1);
    cycle(0, 0, 0, '0, 1, dl(50));
    idle(2);
    check("t6_dout", dout, dl(50));
    check("t6_unf", fifo_unf, 1'b1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, cl(2), 1, dl(20 + i));
    cycle(1, 0, 1, cl(2), 1, dl(30));
    check("t6_rst_vld", dout_vld, 1'b0);
    check("t6_rst_dout", dout, '0);

    // Randomized traffic with occasional sync and reset.
    for (int n = 0; n < 2500; n++) begin
      logic            r, s, cv, dv;
      logic [8*CW-1:0] ci;
      logic [8*DW-1:0] di;
      int              mode;
      mode = $urandom_range(0, 3);
      r  = ($urandom_range(0, 399) == 0);
      s  = ($urandom_range(0, 59) == 0);
      cv = ($urandom_range(0, 99) < (mode == 0 ? 80 : 45));
      dv = ($urandom_range(0, 99) < (mode == 1 ? 80 : 45));
      for (int i = 0; i < 8; i++) begin
        ci[i*CW +: CW] = CW'($urandom);
        case ($urandom_range(0, 5))
          0:       di[i*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
          1:       di[i*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
          default: di[i*DW +: DW] = DW'($urandom);
        endcase
      end
      cycle(r, s, cv, ci, dv, di);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
